// File: rtl/vga_fb_pkg.sv
// Framebuffer geometry and VGA timing constants shared by the scanout arbiter.
// Address helper maps (row, col) of the 320x240 buffer to a word address.
package vga_fb_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam logic [8:0] FB_W     = 9'd320;
  localparam logic [7:0] FB_H     = 8'd240;
  localparam int         FB_AW    = 17;
  localparam logic [FB_AW-1:0] FB_WORDS = 17'd76800;

  // row*320 + col, with 320 = 256 + 64 so no multiplier is needed
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] row, input logic [8:0] col);
    return ({9'd0, row} << 8) + ({9'd0, row} << 6) + {8'd0, col};
  endfunction

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Small synchronous line-prefetch FIFO; flush beats a same-cycle push.
// Zero-latency head; push into a full FIFO without a pop and pop of an empty FIFO are ignored.
module fb_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: line prefetch in hblank has priority, writer gets every other cycle.
// Pixel out 1 cycle after hs; wr_ack is combinational. VGA_FB_STATS_EN adds underflow/write counters.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_W      = 8
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic [9:0]       hs,
  input  logic [9:0]       vs,
  input  logic             wr_req,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ack,
  output logic [FB_AW-1:0] mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] pix_data,
  output logic             underflow
`ifdef VGA_FB_STATS_EN
  ,
  output logic [15:0]      underflow_cnt,
  output logic [15:0]      wr_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic             win_q, win_d, win_eff;
  logic [8:0]       fx_q, fx_d, fx_eff;
  logic [7:0]       fr_q, fr_d;
  logic             infl_q;
  logic [FB_AW-1:0] addr_q, rd_addr;
  logic [PIX_W-1:0] wdata_q;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             underflow_q, underflow_d;

  logic [9:0]       nvs;
  logic             line_start;
  logic [CW:0]      occ;
  logic             rd_go, wr_go, wr_ok;
  logic             scan_act, fifo_pop, uf_evt;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_cnt;

  // Opening the window restarts the fetch in the same cycle, so every
  // quantity the eligibility test uses is taken post-flush here.
  always_comb begin
    nvs        = (vs == V_TOTAL - 10'd1) ? 10'd0 : vs + 10'd1;
    line_start = !rst && (hs == H_ACTIVE) && (nvs < V_ACTIVE);
    win_eff    = win_q || line_start;
    fx_eff     = line_start ? 9'd0 : fx_q;
    fr_d       = line_start ? nvs[8:1] : fr_q;
    occ        = line_start ? '0 : ({1'b0, fifo_cnt} + (CW+1)'(infl_q));
    rd_go      = win_eff && (fx_eff < FB_W) && (occ < DEPTH_V);
    rd_addr    = fb_addr(fr_d, fx_eff);
    wr_go      = !rst && !rd_go && wr_req;
    wr_ok      = wr_go && (wr_addr < FB_WORDS);
    fx_d       = fx_eff + {8'd0, rd_go};
    win_d      = win_eff && (fx_d < FB_W);
  end

  assign mem_addr  = rd_go ? rd_addr : (wr_ok ? wr_addr : addr_q);
  assign mem_we    = wr_ok;
  assign mem_wdata = wr_ok ? wr_data : wdata_q;
  assign wr_ack    = wr_go;

  fb_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk_i      (clk_25),
    .rst_i      (rst),
    .flush_i    (line_start),
    .push_i     (infl_q),
    .push_dat_i (mem_rdata),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // Each fetched word covers two horizontal pixels: pop on even hs, hold on odd.
  always_comb begin
    scan_act = (hs < H_ACTIVE) && (vs < V_ACTIVE);
    fifo_pop = 1'b0;
    uf_evt   = 1'b0;
    pix_d    = pix_q;
    if (!scan_act) begin
      pix_d = '0;
    end else if (!hs[0]) begin
      if (fifo_empty) begin
        pix_d  = '0;
        uf_evt = 1'b1;
      end else begin
        pix_d    = fifo_head;
        fifo_pop = 1'b1;
      end
    end
    underflow_d = underflow_q || uf_evt;
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      win_q       <= 1'b0;
      fx_q        <= '0;
      fr_q        <= '0;
      infl_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      fx_q        <= fx_d;
      fr_q        <= fr_d;
      infl_q      <= rd_go;
      addr_q      <= mem_addr;
      wdata_q     <= mem_wdata;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_data  = pix_q;
  assign underflow = underflow_q;

`ifdef VGA_FB_STATS_EN
  logic [15:0] uf_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      uf_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (uf_evt && (uf_cnt_q != 16'hFFFF)) begin
        uf_cnt_q <= uf_cnt_q + 16'd1;
      end
      // An ack landing on the frame-start cycle belongs to the new frame.
      if ((hs == 10'd0) && (vs == 10'd0)) begin
        wr_cnt_q <= {15'd0, wr_go};
      end else if (wr_go && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign underflow_cnt = uf_cnt_q;
  assign wr_cnt        = wr_cnt_q;
`endif

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port, 320x240x8 framebuffer RAM between two requesters: VGA scanout, which is timed by the 640x480 `hs`/`vs` counters, and a frame writer that stores systolic-array results. The block prefetches each display line into a small FIFO during horizontal blanking and streams it at 2x horizontal and 2x vertical replication. Scanout reads have priority. All remaining RAM cycles are granted to the writer through a req/ack handshake. The block sits between the timing generator, the framebuffer RAM and the DAC pixel register.

## Interface
- `FIFO_DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `PIX_W`, 8: pixel width.
- `clk_25` input 1: 25 MHz pixel clock.
- `rst` input 1: asynchronous, active-high reset.
- `hs` input 10: horizontal counter, 0..799 (active 0..639).
- `vs` input 10: vertical counter, 0..524 (active 0..479).
- `wr_req` input 1: writer request; held high until acked.
- `wr_addr` input 17: framebuffer word address, `row*320+col`.
- `wr_data` input PIX_W: write data.
- `wr_ack` output 1: one-cycle pulse in the cycle the write is driven to RAM.
- `mem_addr` output 17: RAM address.
- `mem_we` output 1: RAM write enable.
- `mem_wdata` output PIX_W: RAM write data.
- `mem_rdata` input PIX_W: RAM read data, valid 1 cycle after a read address.
- `pix_data` output PIX_W: registered pixel to the DAC; 0 outside the active area.
- `underflow` output 1: sticky flag; cleared only by reset.

## Operation
- The line window opens at `hs==640`. If `nvs` is below 480, the block flushes the FIFO and the in-flight read, sets fetch column `fx=0`, and sets fetch row `fr=nvs>>1`.
  - `nvs` is 0 when `vs==524`, otherwise `vs+1`.
- The read is eligible when all of the following hold:
  - the window is open;
  - `fx<320`;
  - `count + inflight < FIFO_DEPTH`.
- An eligible read takes the RAM cycle:
  - `mem_addr = fr*320+fx`, `mem_we=0`;
  - `fx` increments;
  - `mem_rdata` is pushed into the FIFO on the next cycle.
- The window closes when `fx==320`.
- The writer is granted a cycle when no read is issued and `wr_req=1`:
  - `mem_addr=wr_addr`, `mem_we=1`, `mem_wdata=wr_data`, `wr_ack=1`.
  - If `wr_addr≥76800`, the block asserts `wr_ack` with `mem_we=0`; the write is dropped.
- Idle cycle (no read, no write): `mem_we=0`, and `mem_addr` holds its last value.
- Scanout, applied when `hs<640`, `vs<480` and `hs[0]==0`:
  - `pix_data <=` FIFO head, and the FIFO pops.
  - If the FIFO is empty, `pix_data <= 0` and `underflow <= 1`.
- On active cycles with `hs[0]==1`, `pix_data` holds its value.
- Outside the active area, `pix_data <= 0`.
- Read demand during active video is at most 1 per 2 cycles, so the writer is guaranteed at least 50% of active cycles and all of vertical blanking.

## Timing
- Reset values: `pix_data=0`, `mem_addr=0`, `mem_we=0`, `mem_wdata=0`, `wr_ack=0`, `underflow=0`, FIFO empty, window closed.
- After reset is released mid-frame:
  - no fetch happens until the next `hs==640` with `nvs<480`;
  - active pixels before that point underflow.
- Pixel latency: the pixel for `hs=h` appears on `pix_data` in the cycle after `hs=h`. Downstream syncs must be delayed by 1 cycle.
- Read latency: address in cycle N, FIFO push in cycle N+1.
- If push and pop happen in the same cycle, the count is unchanged.
- If the flush at `hs==640` coincides with a pending push, the flush wins and the push is discarded.
- Pre-fill: `FIFO_DEPTH` reads in the first `FIFO_DEPTH` cycles of the window, well before the next `hs==0`.
- `wr_ack` latency: the same cycle as `wr_req` when no read is eligible, otherwise the first non-read cycle. `wr_req` must not drop before ack.

## Configuration
- `VGA_FB_STATS_EN` defined adds output ports:
  - `underflow_cnt[15:0]`: saturating; increments once per underflowing pixel.
  - `wr_cnt[15:0]`: acked writes in the current frame; cleared at `vs==0 && hs==0`.
  - Both reset to 0.
- `VGA_FB_STATS_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- `vga_fb_pkg` holds:
  - `H_ACTIVE=640`, `H_TOTAL=800`, `V_ACTIVE=480`, `V_TOTAL=525`;
  - `FB_W=320`, `FB_H=240`, `FB_WORDS=76800`;
  - `FB_AW=17`.
- Sub-module `fb_prefetch_fifo`: synchronous FIFO with flush, push, pop, count, head and empty; asynchronous reset.
- Arbitration, fetch counters and scanout registers live in the top level.

## Test plan
- Line-0 prefill: RAM[i]=i[7:0], `wr_req=0`. At `vs=524, hs=640..643` → reads of addr 0..3. `pix_data` then reads 0,0,1,1,2,2,… one cycle after `hs=0,1,2,…`.
- Line doubling: lines `vs=2` and `vs=3` both read row 1 (addr 320..639), so identical pixel streams appear on both.
- Write contention: `wr_req` held continuously during active video → the acked writes fall only in cycles with no read and total ≥319 per active line. `wr_addr=80000` → `wr_ack` with `mem_we=0`.
- Reset mid-line: `rst` pulsed at `vs=100, hs=300` → all outputs 0. Line 100 underflows from `hs=302`, so `underflow=1`. Line 101 is correct.
- Writer visibility: during vertical blanking, write 0xAB to addr 0 → the next frame shows `pix_data=0xAB` for `hs=0,1` of lines 0 and 1.
- With `VGA_FB_STATS_EN`: hold the FIFO starved for one full active line → `underflow_cnt=320`. 10 acked writes in a frame → `wr_cnt=10`, then 0 after `vs=0, hs=0`.
